// File: rtl/cam_ctrl_scheduler.sv
// Camera control scheduler: sequences sensor power-up, hands off to the register-init
// engine, then arbitrates two runtime SCCB write requesters round-robin with a write timeout.
module cam_ctrl_scheduler #(
  parameter logic [7:0] DEV_ADDR    = 8'h78,
  parameter int         T_PWDN_CYC  = 25000,
  parameter int         T_RST_CYC   = 25000,
  parameter int         T_BOOT_CYC  = 500000,
  parameter int         TIMEOUT_CYC = 2500000
) (
  input  logic        clk_25m,
  input  logic        camera_rstn,
  output logic        cam_pwdn,
  output logic        cam_resetb,
  output logic        init_en,
  input  logic        init_done,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] req0_data,
  input  logic [23:0] req1_data,
  output logic        ack0,
  output logic        ack1,
  output logic        ack_err,
  output logic        wr_start,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  output logic        ready,
  output logic        err_sticky
);

  typedef enum logic [2:0] {
    S_PWDN, S_RST, S_BOOT, S_INIT, S_IDLE, S_XFER
  } state_t;

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic        rr_ptr, rr_ptr_nx;
  logic        gnt, gnt_nx;
  logic        pick;
  logic [31:0] wr_data_nx;
  logic        ack0_nx, ack1_nx, ack_err_nx, err_nx, ready_nx;

  // When both lines request, the pointer side wins; otherwise the only requester does.
  assign pick = (req0 && req1) ? rr_ptr : req1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_nx   = state;
    cnt_nx     = cnt;
    rr_ptr_nx  = rr_ptr;
    gnt_nx     = gnt;
    wr_data_nx = wr_data;
    ack0_nx    = 1'b0;
    ack1_nx    = 1'b0;
    ack_err_nx = 1'b0;
    err_nx     = err_sticky;
    case (state)
      S_PWDN: begin
        if (cnt == 32'd0) begin
          state_nx = S_RST;
          cnt_nx   = 32'(T_RST_CYC - 1);
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      S_RST: begin
        if (cnt == 32'd0) begin
          state_nx = S_BOOT;
          cnt_nx   = 32'(T_BOOT_CYC - 1);
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      S_BOOT: begin
        if (cnt == 32'd0) begin
          state_nx = S_INIT;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      S_INIT: begin
        if (init_done) state_nx = S_IDLE;
      end
      S_IDLE: begin
        // ready is low on the IDLE entry cycle, so a line just acked cannot be regranted.
        if (ready && (req0 || req1)) begin
          state_nx   = S_XFER;
          gnt_nx     = pick;
          rr_ptr_nx  = ~pick;
          wr_data_nx = {DEV_ADDR, pick ? req1_data : req0_data};
          cnt_nx     = 32'(TIMEOUT_CYC - 1);
        end
      end
      S_XFER: begin
        if (wr_done || cnt == 32'd0) begin
          state_nx   = S_IDLE;
          ack0_nx    = ~gnt;
          ack1_nx    = gnt;
          ack_err_nx = ~wr_done;
          err_nx     = err_sticky | ~wr_done;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      default: state_nx = S_PWDN;
    endcase
    ready_nx = (state == S_IDLE) && (state_nx == S_IDLE);
  end

  // Pin and handshake outputs are registered decodes of the next state, so they align with state.
  always_ff @(posedge clk_25m or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state      <= S_PWDN;
      cnt        <= 32'(T_PWDN_CYC - 1);
      rr_ptr     <= 1'b0;
      gnt        <= 1'b0;
      cam_pwdn   <= 1'b1;
      cam_resetb <= 1'b0;
      init_en    <= 1'b0;
      wr_start   <= 1'b0;
      wr_data    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      ack_err    <= 1'b0;
      ready      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rr_ptr     <= rr_ptr_nx;
      gnt        <= gnt_nx;
      cam_pwdn   <= (state_nx == S_PWDN);
      cam_resetb <= !(state_nx == S_PWDN || state_nx == S_RST);
      init_en    <= (state_nx == S_INIT);
      wr_start   <= (state_nx == S_XFER);
      wr_data    <= wr_data_nx;
      ack0       <= ack0_nx;
      ack1       <= ack1_nx;
      ack_err    <= ack_err_nx;
      ready      <= ready_nx;
      err_sticky <= err_nx;
    end
  end

endmodule

// File: tb/tb_cam_ctrl_scheduler.sv
// Bench for cam_ctrl_scheduler: power-up timing, INIT hand-off, round-robin writes with
// random data/latency against a transaction-level model, timeout and mid-transfer reset.
module tb_cam_ctrl_scheduler;

  logic        clk_25m = 1'b0;
  logic        camera_rstn = 1'b0;
  logic        cam_pwdn, cam_resetb, init_en;
  logic        init_done = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [23:0] req0_data = '0, req1_data = '0;
  logic        ack0, ack1, ack_err, wr_start;
  logic [31:0] wr_data;
  logic        wr_done = 1'b0;
  logic        ready, err_sticky;

  int errors = 0;
  int checks = 0;
  bit pref = 1'b0;  // model: which requester wins a tie next

  cam_ctrl_scheduler #(
    .DEV_ADDR(8'h78), .T_PWDN_CYC(4), .T_RST_CYC(4), .T_BOOT_CYC(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk_25m(clk_25m), .camera_rstn(camera_rstn),
    .cam_pwdn(cam_pwdn), .cam_resetb(cam_resetb),
    .init_en(init_en), .init_done(init_done),
    .req0(req0), .req1(req1), .req0_data(req0_data), .req1_data(req1_data),
    .ack0(ack0), .ack1(ack1), .ack_err(ack_err),
    .wr_start(wr_start), .wr_data(wr_data), .wr_done(wr_done),
    .ready(ready), .err_sticky(err_sticky)
  );

  always #20 clk_25m = ~clk_25m;

  task automatic test_reset();
    repeat (2) @(negedge clk_25m);
    checks++;
    if ({cam_pwdn, cam_resetb, init_en, wr_start, ack0, ack1, ack_err, ready, err_sticky} !== 9'b100000000) begin
      errors++;
      $display("FAIL reset_outputs: got pwdn=%b resetb=%b init_en=%b wr_start=%b ack0=%b ack1=%b ack_err=%b ready=%b err=%b, want 1 0 0 0 0 0 0 0 0",
               cam_pwdn, cam_resetb, init_en, wr_start, ack0, ack1, ack_err, ready, err_sticky);
    end
    checks++;
    if (wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_wr_data: got %h want 00000000", wr_data);
    end
  endtask

  // Releases reset and walks the power-up sequence, ending two cycles after init_done.
  task automatic run_powerup();
    int n;
    bit acked;
    acked = 1'b0;
    @(negedge clk_25m);
    camera_rstn = 1'b1;
    n = 0;
    do begin @(negedge clk_25m); n++; acked |= ack0 | ack1; end while (cam_pwdn && n < 50);
    checks++;
    if (n != 4 || cam_resetb !== 1'b0) begin
      errors++;
      $display("FAIL pwdn_hold: got %0d cycles (resetb=%b) want 4 (resetb=0)", n, cam_resetb);
    end
    n = 0;
    do begin @(negedge clk_25m); n++; acked |= ack0 | ack1; end while (!cam_resetb && n < 50);
    checks++;
    if (n != 4 || cam_pwdn !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: got %0d cycles (pwdn=%b) want 4 (pwdn=0)", n, cam_pwdn);
    end
    n = 0;
    do begin @(negedge clk_25m); n++; acked |= ack0 | ack1; end while (!init_en && n < 50);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL boot_hold: got %0d cycles want 8", n);
    end
    repeat (9) begin @(negedge clk_25m); acked |= ack0 | ack1 | wr_start; end
    checks++;
    if (init_en !== 1'b1 || acked || ready !== 1'b0) begin
      errors++;
      $display("FAIL init_wait: got init_en=%b ack_or_start_seen=%b ready=%b want 1 0 0", init_en, acked, ready);
    end
    init_done = 1'b1;
    @(negedge clk_25m);
    checks++;
    if (init_en !== 1'b0 || ready !== 1'b0 || cam_resetb !== 1'b1) begin
      errors++;
      $display("FAIL init_exit: got init_en=%b ready=%b resetb=%b want 0 0 1", init_en, ready, cam_resetb);
    end
    @(negedge clk_25m);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b want 1", ready);
    end
  endtask

  // Serves the next grant predicted by the model, returning wr_done after `delay` cycles.
  task automatic serve(input int delay);
    bit w;
    logic [31:0] exp;
    int n;
    w = (req0 && req1) ? pref : req1;
    pref = ~w;
    exp = {8'h78, w ? req1_data : req0_data};
    n = 0;
    while (!wr_start && n < 40) begin @(negedge clk_25m); n++; end
    checks++;
    if (wr_start !== 1'b1) begin
      errors++;
      $display("FAIL grant_wait: wr_start=%b after %0d cycles, want 1", wr_start, n);
    end
    checks++;
    if (wr_data !== exp) begin
      errors++;
      $display("FAIL grant_data: got %h want %h (req%0d)", wr_data, exp, w);
    end
    repeat (delay) @(negedge clk_25m);
    checks++;
    if (wr_start !== 1'b1 || wr_data !== exp || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL xfer_hold: got wr_start=%b wr_data=%h acks=%b%b want 1 %h 00", wr_start, wr_data, ack0, ack1, exp);
    end
    wr_done = 1'b1;
    @(negedge clk_25m);
    wr_done = 1'b0;
    checks++;
    if ({ack0, ack1, ack_err, wr_start} !== {~w, w, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ack: got ack0=%b ack1=%b ack_err=%b wr_start=%b want %b %b 0 0", ack0, ack1, ack_err, wr_start, ~w, w);
    end
    if (w) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic test_powerup();
    req1 = 1'b1;
    req1_data = 24'h474101;
    run_powerup();
    serve($urandom_range(0, 5));
  endtask

  task automatic test_round_robin();
    req0 = 1'b1; req0_data = 24'h503d80;
    req1 = 1'b1; req1_data = 24'h474101;
    serve(2);
    serve(0);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 3);
      if (!req0 && (r[0] || !req1)) begin req0 = 1'b1; req0_data = 24'($urandom); end
      if (!req1 && r[1]) begin req1 = 1'b1; req1_data = 24'($urandom); end
      serve($urandom_range(0, 12));
    end
    while (req0 || req1) serve($urandom_range(0, 12));
  endtask

  task automatic test_spurious_done();
    repeat (2) @(negedge clk_25m);
    wr_done = 1'b1;
    @(negedge clk_25m);
    wr_done = 1'b0;
    @(negedge clk_25m);
    checks++;
    if ({ack0, ack1, ack_err, wr_start, ready, err_sticky} !== 6'b000010) begin
      errors++;
      $display("FAIL spurious_done: got ack0=%b ack1=%b ack_err=%b wr_start=%b ready=%b err=%b want 0 0 0 0 1 0",
               ack0, ack1, ack_err, wr_start, ready, err_sticky);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit w;
    req0 = 1'b1;
    req0_data = 24'($urandom);
    w = 1'b0;
    pref = ~w;
    n = 0;
    while (!wr_start && n < 40) begin @(negedge clk_25m); n++; end
    n = 0;
    while (wr_start && n < 40) begin @(negedge clk_25m); n++; end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_len: wr_start high %0d cycles want 16", n);
    end
    checks++;
    if ({ack0, ack1, ack_err, err_sticky, ready} !== 5'b10110) begin
      errors++;
      $display("FAIL timeout_ack: got ack0=%b ack1=%b ack_err=%b err=%b ready=%b want 1 0 1 1 0",
               ack0, ack1, ack_err, err_sticky, ready);
    end
    req0 = 1'b0;
    @(negedge clk_25m);
    checks++;
    if (ready !== 1'b1 || err_sticky !== 1'b1 || ack0 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got ready=%b err=%b ack0=%b want 1 1 0", ready, err_sticky, ack0);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    bit acked;
    req1 = 1'b1;
    req1_data = 24'($urandom);
    n = 0;
    while (!wr_start && n < 40) begin @(negedge clk_25m); n++; end
    repeat (3) @(negedge clk_25m);
    camera_rstn = 1'b0;
    #1;
    checks++;
    if ({wr_start, cam_pwdn, cam_resetb, init_en, ack0, ack1, ready, err_sticky} !== 8'b01000000 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: got wr_start=%b pwdn=%b resetb=%b init_en=%b acks=%b%b ready=%b err=%b wr_data=%h want 0 1 0 0 00 0 0 00000000",
               wr_start, cam_pwdn, cam_resetb, init_en, ack0, ack1, ready, err_sticky, wr_data);
    end
    req1 = 1'b0;
    init_done = 1'b0;
    pref = 1'b0;
    acked = 1'b0;
    repeat (3) begin @(negedge clk_25m); acked |= ack0 | ack1; end
    checks++;
    if (acked) begin
      errors++;
      $display("FAIL reset_no_ack: ack seen during reset, want none");
    end
    run_powerup();
    req0 = 1'b1; req0_data = 24'($urandom);
    req1 = 1'b1; req1_data = 24'($urandom);
    serve($urandom_range(0, 12));
    serve($urandom_range(0, 12));
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_round_robin();
    test_random();
    test_spurious_done();
    test_timeout();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
